// File: rtl/pin_gather_arb_pkg.sv
// pin_gather_arb_pkg: FSM state encoding and popcount helper shared by the pin gather arbiter
package pin_gather_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        RESP     = 2'd2
    } state_t;

    localparam int POP_MAX = 256;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/pin_compress.sv
// pin_compress: packs the data bits at set mask positions, lowest first, into the result LSBs
module pin_compress #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] result
);

    // walk pins from the top down so the lowest selected pin lands in bit 0
    always_comb begin
        result = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (mask[i]) result = (result << 1) | WIDTH'(data[i]);
    end

endmodule

// File: rtl/pin_gather_arb.sv
// pin_gather_arb: round-robin arbiter serving masked pin-gather requests through one compressor
module pin_gather_arb
    import pin_gather_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           io_in,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_mask,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(WIDTH+1)-1:0] rsp_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(NREQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      id_q, id_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CW-1:0]      rsp_count_q, rsp_count_d;
    logic               armed_q, armed_d;
    logic [WIDTH-1:0]   packed_w;
    logic [POP_MAX-1:0] mask_ext;
    logic [IW-1:0]      gnt;
    logic [IW-1:0]      idx;
    logic [IW:0]        sum;
    logic               found;

    pin_compress #(.WIDTH(WIDTH)) u_compress (
        .data   (data_q),
        .mask   (mask_q),
        .result (packed_w)
    );

    // round-robin search: first valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    // next state, handshake strobes and register loads; strobes are held low while in reset
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        mask_d      = mask_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_count_d = rsp_count_q;
        armed_d     = 1'b1;
        req_ready   = '0;
        rsp_valid   = '0;
        mask_ext    = '0;
        mask_ext[WIDTH-1:0] = mask_q;
        case (state_q)
            IDLE: begin
                if (found && armed_q && rst_n) begin
                    req_ready[gnt] = 1'b1;
                    id_d           = gnt;
                    mask_d         = req_mask[int'(gnt)*WIDTH +: WIDTH];
                    data_d         = io_in;
                    state_d        = COMPRESS;
                end
            end
            COMPRESS: begin
                rsp_data_d  = packed_w;
                rsp_count_d = CW'(popcount(mask_ext));
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid[id_q] = rst_n;
                if (rsp_ready[id_q]) begin
                    rr_ptr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset drops any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_count_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_count_q <= rsp_count_d;
            armed_q     <= armed_d;
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_pin_gather_arb.sv
// tb_pin_gather_arb: directed stimulus with a transaction-level model checked every cycle
module tb_pin_gather_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] io_in = '0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_mask = '0;
    logic [3:0]  rsp_ready = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_count;

    int checks = 0;
    int errors = 0;

    pin_gather_arb #(.WIDTH(16), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_in     (io_in),
        .req_valid (req_valid),
        .req_mask  (req_mask),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_count (rsp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] gather(input logic [15:0] m, input logic [15:0] d);
        logic [15:0] r;
        int j;
        r = '0;
        j = 0;
        for (int i = 0; i < 16; i++)
            if (m[i]) begin
                r[4'(j)] = d[i];
                j++;
            end
        return r;
    endfunction

    function automatic int ones(input logic [15:0] m);
        int c;
        c = 0;
        for (int i = 0; i < 16; i++) c += int'(m[i]);
        return c;
    endfunction

    // transaction-level model: phase 0 waiting, 1 accepted, 2 responding
    int          m_phase = 0;
    int          m_id = 0;
    int          m_rr = 0;
    int          m_g;
    bit          m_en = 1'b0;
    logic [15:0] m_data = '0;
    logic [15:0] m_pd = '0;
    int          m_cnt = 0;
    int          m_pc = 0;
    logic [3:0]  e_ready;
    logic [3:0]  e_valid;

    always @(negedge clk) begin
        e_ready = '0;
        e_valid = '0;
        m_g = -1;
        if (rst_n && m_en && m_phase == 0)
            for (int k = 0; k < 4; k++)
                if (m_g < 0 && req_valid[2'((m_rr + k) % 4)]) m_g = (m_rr + k) % 4;
        if (m_g >= 0) e_ready[2'(m_g)] = 1'b1;
        if (rst_n && m_phase == 2) e_valid[2'(m_id)] = 1'b1;
        chk("model_req_ready", 32'(req_ready), 32'(e_ready));
        chk("model_rsp_valid", 32'(rsp_valid), 32'(e_valid));
        if (e_valid != 0) begin
            chk("model_rsp_data", 32'(rsp_data), 32'(m_data));
            chk("model_rsp_count", 32'(rsp_count), 32'(m_cnt));
        end
        if (!rst_n) begin
            m_phase = 0;
            m_rr    = 0;
            m_en    = 1'b0;
            m_data  = '0;
            m_cnt   = 0;
        end else begin
            m_en = 1'b1;
            if (m_phase == 0 && m_g >= 0) begin
                m_id    = m_g;
                m_pd    = gather(req_mask[m_g*16 +: 16], io_in);
                m_pc    = ones(req_mask[m_g*16 +: 16]);
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_data  = m_pd;
                m_cnt   = m_pc;
                m_phase = 2;
            end else if (m_phase == 2 && rsp_ready[2'(m_id)]) begin
                m_rr    = (m_id + 1) % 4;
                m_phase = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one request from a single requester; io_in is inverted right after acceptance
    task automatic txn(input int id, input logic [15:0] m, input logic [15:0] io,
                       input logic [15:0] ed, input int ec, input int hold);
        int lat;
        req_valid = 4'(1 << id);
        req_mask = '0;
        req_mask[id*16 +: 16] = m;
        io_in = io;
        rsp_ready = '0;
        @(negedge clk);
        chk("accept_ready", 32'(req_ready), 32'(1 << id));
        lat = 0;
        do begin
            step();
            lat++;
            if (lat == 1) begin
                req_valid = '0;
                io_in = ~io;
            end
            @(negedge clk);
        end while (rsp_valid == 0 && lat < 8);
        chk("latency", 32'(lat), 32'd2);
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << id));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_count", 32'(rsp_count), 32'(ec));
        for (int h = 0; h < hold; h++) begin
            step();
            req_valid = '1;
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'(1 << id));
            chk("bp_data", 32'(rsp_data), 32'(ed));
            chk("bp_count", 32'(rsp_count), 32'(ec));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        step();
        req_valid = '0;
        rsp_ready = '1;
        step();
        rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int g_cyc[5];
        logic [3:0] g_vec[5];
        int lat;

        chk("pin_model_1B", 32'(gather(16'h4945, 16'h9D35)), 32'h001B);
        chk("pin_model_cnt6", 32'(ones(16'h4945)), 32'd6);
        chk("pin_model_F0", 32'(gather(16'h00F0, 16'hFFFF)), 32'h000F);

        req_valid = '1;
        repeat (3) step();
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_req_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = '0;
        step();

        txn(0, 16'h4945, 16'h9D35, 16'h001B, 6, 0);
        txn(2, 16'h00F0, 16'hFFFF, 16'h000F, 4, 5);
        txn(3, 16'h0000, 16'h1234, 16'h0000, 0, 0);
        txn(1, 16'hFFFF, 16'hA5C3, 16'hA5C3, 16, 0);

        req_valid = 4'b0100;
        req_mask = '0;
        req_mask[32 +: 16] = 16'h00FF;
        io_in = 16'h1234;
        lat = 0;
        do begin
            step();
            lat++;
            @(negedge clk);
        end while (rsp_valid == 0 && lat < 8);
        chk("pre_reset_valid", 32'(rsp_valid), 32'b0100);
        step();
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("in_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        req_valid = '1;
        rsp_ready = '1;
        req_mask = {16'hF000, 16'h0F00, 16'h00F0, 16'h000F};
        io_in = 16'hC3A5;
        @(negedge clk);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                g_cyc[n] = cyc;
                g_vec[n] = rsp_valid;
                n++;
            end
        end
        chk("fair_grants", 32'(n), 32'd5);
        for (int k = 0; k < n; k++) begin
            chk("fair_order", 32'(g_vec[k]), 32'(1 << (k % 4)));
            if (k > 0) chk("fair_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
        end
        step();
        req_valid = '0;
        rsp_ready = '0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pin_gather_arb.md
PIN_GATHER_ARB -- requirements
Module: pin_gather_arb

Interface
REQ-001 Parameter WIDTH, default 16, is the number of I/O pins sampled and the width of mask and result.
REQ-002 Parameter NREQ, default 4, is the number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 io_in  input  WIDTH  pin values, already synchronised to clk.
REQ-006 req_valid  input  NREQ  per-requester gather request.
REQ-007 req_mask  input  NREQ*WIDTH  per-requester pin mask; slice i is bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  one-hot accept strobe.
REQ-009 rsp_valid  output  NREQ  one-hot response valid.
REQ-010 rsp_ready  input  NREQ  per-requester response accept.
REQ-011 rsp_data  output  WIDTH  packed result; shared by all requesters and qualified by rsp_valid.
REQ-012 rsp_count  output  $clog2(WIDTH+1)  popcount of the served mask.

Function
REQ-013 FSM states: IDLE, COMPRESS, RESP; 2-bit encoding.
REQ-014 IDLE with any req_valid: grant the first set req_valid at or after rr_ptr, scanning upward modulo NREQ; assert req_ready[grant] combinationally in that cycle only; latch grant id, req_mask slice and io_in; go to COMPRESS.
REQ-015 IDLE with no req_valid: req_ready all zero; remain in IDLE.
REQ-016 COMPRESS: register rsp_data = compress(latched io_in, latched mask) and rsp_count = popcount(latched mask); go to RESP.
REQ-017 compress: the bits of data at set mask positions are packed, in ascending order, into the LSBs of the result; upper bits are zero.
REQ-018 RESP: rsp_valid[id] = 1 and all other bits 0; rsp_data and rsp_count are held stable.
REQ-019 RESP with rsp_ready[id] = 1: go to IDLE the next cycle and set rr_ptr to (id+1) mod NREQ; rsp_ready on other bits is ignored.
REQ-020 Latency: accept in cycle T gives rsp_valid in cycle T+2; minimum of 3 cycles per transaction; req_ready is 0 outside IDLE.
REQ-021 A requester may drop req_valid before it is accepted; no state change results.
REQ-022 Pin sampling uses io_in only in the accept cycle; later io_in changes do not affect the response.
REQ-023 A zero mask gives rsp_data 0 and rsp_count 0; an all-ones mask gives rsp_data = io_in and rsp_count = WIDTH.
REQ-024 The rr_ptr wraps from NREQ-1 to 0.
REQ-025 rsp_ready held high before RESP is legal, and the response completes in the first RESP cycle.

Reset
REQ-026 On rst_n = 0 at a clock edge: state is IDLE, rr_ptr is 0, and rsp_data, rsp_count and latched registers are 0.
REQ-027 During reset and in the first cycle after it: req_ready and rsp_valid are all zero.
REQ-028 A reset in COMPRESS or RESP silently discards the in-flight transaction; no response is issued.

Structure
REQ-029 A shared package holds the FSM state constants and a popcount function.
REQ-030 The datapath is one instance of the existing pin_compress module (WIDTH passed through), fed by the latched data and mask.
REQ-031 The arbiter, FSM and output registers are in pin_gather_arb; no other sub-modules.

Verification
REQ-032 Single request: WIDTH=16, req0 mask 0x4945, io_in 0x9D35 at accept -> after 2 cycles rsp_valid=0001, rsp_data 0x001B, rsp_count 6.
REQ-033 Fairness: all four req_valid held high and rsp_ready high -> grants in order 0,1,2,3,0, with each rsp_valid 3 cycles apart.
REQ-034 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_count stable, and req_ready stays 0 throughout.
REQ-035 io_in change: io_in goes from 0xFFFF to 0x0000 the cycle after accept with mask 0x00F0 -> rsp_data 0x000F.
REQ-036 Reset in RESP: rst_n low for 1 cycle -> rsp_valid 0, then the next grant is taken from requester 0.
REQ-037 Boundaries: mask 0x0000 -> data 0, count 0; mask 0xFFFF with io_in 0xA5C3 -> data 0xA5C3, count 16.
